// File: rtl/fifo_rr_arbiter_if.sv
// Handshake bundle between N requesters, the round-robin arbiter and one FIFO write port.
// master: arbiter side; slave: requester/FIFO environment side.
interface fifo_rr_arbiter_if #(
  parameter int NUM_REQ      = 4,
  parameter int NUM_REQ_LOG2 = 2,
  parameter int DATA_WIDTH   = 32
);
  logic [NUM_REQ-1:0]            s_valid;
  logic [NUM_REQ-1:0]            s_ready;
  logic [NUM_REQ*DATA_WIDTH-1:0] s_data;
  logic                          m_valid;
  logic                          m_ready;
  logic [DATA_WIDTH-1:0]         m_data;
  logic [NUM_REQ_LOG2-1:0]       m_id;

  modport master (
    input  s_valid, s_data, m_ready,
    output s_ready, m_valid, m_data, m_id
  );

  modport slave (
    output s_valid, s_data, m_ready,
    input  s_ready, m_valid, m_data, m_id
  );
endinterface

// File: rtl/fifo_rr_arbiter.sv
// Round-robin arbiter with bounded bursts feeding a single FIFO write port.
// Optional beat_total counter enabled by FIFO_RR_ARBITER_STATS_EN.
module fifo_rr_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int NUM_REQ_LOG2 = 2,
  parameter int DATA_WIDTH   = 32,
  parameter int MAX_BURST    = 4
) (
  input  logic clk,
  input  logic reset,
  fifo_rr_arbiter_if.master bus,
  output logic busy
`ifdef FIFO_RR_ARBITER_STATS_EN
  ,
  output logic [31:0] beat_total
`endif
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  state_e                  state_q, state_d;
  logic [NUM_REQ_LOG2-1:0] gnt_q, gnt_d;
  logic [NUM_REQ_LOG2-1:0] rr_ptr_q, rr_ptr_d;
  logic [7:0]              beat_cnt_q, beat_cnt_d;

  logic [NUM_REQ_LOG2-1:0] pick;
  logic [NUM_REQ_LOG2-1:0] gnt_inc;
  logic [DATA_WIDTH-1:0]   req_data [NUM_REQ];
  logic                    xfer;
  logic                    last_beat;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_data
    assign req_data[i] = bus.s_data[i*DATA_WIDTH +: DATA_WIDTH];
  end

  // Scan downward so the lowest offset from rr_ptr wins.
  always_comb begin
    pick = rr_ptr_q;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      int idx;
      idx = int'(rr_ptr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (bus.s_valid[NUM_REQ_LOG2'(idx)])
        pick = NUM_REQ_LOG2'(idx);
    end
  end

  assign gnt_inc = (int'(gnt_q) == NUM_REQ - 1)
                 ? '0 : gnt_q + 1'b1;
  assign last_beat = (beat_cnt_q == 8'(MAX_BURST - 1));
  assign xfer = bus.m_valid && bus.m_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      gnt_q      <= '0;
      rr_ptr_q   <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    rr_ptr_d   = rr_ptr_q;
    beat_cnt_d = beat_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (|bus.s_valid) begin
          state_d    = GRANT;
          gnt_d      = pick;
          beat_cnt_d = '0;
        end
      end
      GRANT: begin
        if (xfer)
          beat_cnt_d = beat_cnt_q + 8'd1;
        if (!bus.s_valid[gnt_q] || (xfer && last_beat)) begin
          state_d  = IDLE;
          rr_ptr_d = gnt_inc;
        end
      end
      default: ;
    endcase
  end

  // Handshakes are gated by reset so an abandoned burst moves no beat.
  always_comb begin
    bus.s_ready = '0;
    bus.m_valid = 1'b0;
    bus.m_data  = '0;
    bus.m_id    = '0;
    busy        = 1'b0;
    if (state_q == GRANT) begin
      busy               = 1'b1;
      bus.m_id           = gnt_q;
      bus.m_data         = req_data[gnt_q];
      bus.m_valid        = bus.s_valid[gnt_q] && !reset;
      bus.s_ready[gnt_q] = bus.m_ready && !reset;
    end
  end

`ifdef FIFO_RR_ARBITER_STATS_EN
  logic [31:0] beat_total_q;

  always_ff @(posedge clk) begin
    if (reset)
      beat_total_q <= '0;
    else if (xfer)
      beat_total_q <= beat_total_q + 32'd1;
  end

  assign beat_total = beat_total_q;
`endif

endmodule

// File: tb/tb_fifo_rr_arbiter.sv
// Self-checking bench: directed scenarios plus random traffic vs a transaction model.
// Drives a MAX_BURST=4 and a MAX_BURST=1 instance from the same stimulus.
module tb_fifo_rr_arbiter;

  logic         clk;
  logic         rst;
  logic [3:0]   sv;
  logic         mr;
  logic [127:0] sd;
  logic         busy0, busy1;
`ifdef FIFO_RR_ARBITER_STATS_EN
  logic [31:0]  bt0, bt1;
`endif

  int checks   = 0;
  int failures = 0;

  int own [2] = '{-1, -1};
  int ptr [2] = '{0, 0};
  int cnt [2] = '{0, 0};
  int tot [2] = '{0, 0};
  int mb  [2] = '{4, 1};

  fifo_rr_arbiter_if #(.NUM_REQ(4), .NUM_REQ_LOG2(2), .DATA_WIDTH(32)) bus0 ();
  fifo_rr_arbiter_if #(.NUM_REQ(4), .NUM_REQ_LOG2(2), .DATA_WIDTH(32)) bus1 ();

  assign bus0.s_valid = sv;
  assign bus0.s_data  = sd;
  assign bus0.m_ready = mr;
  assign bus1.s_valid = sv;
  assign bus1.s_data  = sd;
  assign bus1.m_ready = mr;

  fifo_rr_arbiter #(
    .NUM_REQ(4), .NUM_REQ_LOG2(2), .DATA_WIDTH(32), .MAX_BURST(4)
  ) dut (
    .clk(clk), .reset(rst), .bus(bus0), .busy(busy0)
`ifdef FIFO_RR_ARBITER_STATS_EN
    , .beat_total(bt0)
`endif
  );

  fifo_rr_arbiter #(
    .NUM_REQ(4), .NUM_REQ_LOG2(2), .DATA_WIDTH(32), .MAX_BURST(1)
  ) dut1 (
    .clk(clk), .reset(rst), .bus(bus1), .busy(busy1)
`ifdef FIFO_RR_ARBITER_STATS_EN
    , .beat_total(bt1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Grant-level model: owner -1 means nobody holds the port.
  function automatic void model_step(int u);
    if (rst) begin
      own[u] = -1; ptr[u] = 0; cnt[u] = 0; tot[u] = 0;
    end else if (own[u] < 0) begin
      int nxt = -1;
      for (int k = 0; k < 4; k++) begin
        int r = (ptr[u] + k) % 4;
        if (nxt < 0 && sv[r]) nxt = r;
      end
      own[u] = nxt;
      cnt[u] = 0;
    end else if (!sv[own[u]]) begin
      ptr[u] = (own[u] + 1) % 4;
      own[u] = -1;
    end else if (mr) begin
      tot[u]++;
      cnt[u]++;
      if (cnt[u] == mb[u]) begin
        ptr[u] = (own[u] + 1) % 4;
        own[u] = -1;
      end
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step(0);
    model_step(1);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; sv = '0; mr = 1'b0;
    #1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++;
    if ({busy0, bus0.m_valid, bus0.s_ready} !== 6'b0 ||
        bus0.m_data !== 32'h0 || bus0.m_id !== 2'd0) begin
      failures++;
      $display("FAIL reset_outputs busy=%b v=%b rdy=%b d=%h id=%0d want all 0",
               busy0, bus0.m_valid, bus0.s_ready, bus0.m_data, bus0.m_id);
    end
    rst = 1'b1; sv = 4'b1111; mr = 1'b1;
    tick();
    #1;
    checks++;
    if (busy0 !== 1'b0 || bus0.s_ready !== 4'b0) begin
      failures++;
      $display("FAIL reset_held busy=%b rdy=%b want 0/0", busy0, bus0.s_ready);
    end
    rst = 1'b0;
    checks++;
    if (bus0.m_valid !== 1'b0 || busy0 !== 1'b0) begin
      failures++;
      $display("FAIL reset_bubble v=%b busy=%b want 0/0", bus0.m_valid, busy0);
    end
    tick();
    sv = '0;
  endtask

  task automatic test_burst();
    do_reset();
    mr = 1'b1; sv = 4'b0100;
    for (int c = 0; c < 9; c++) begin
      logic ev, eb;
      sd[64 +: 32] = 32'hA000_0000 + 32'(c);
      if (c == 8) sv = '0;
      ev = !(c == 0 || c == 5 || c == 8);
      eb = !(c == 0 || c == 5);
      #1;
      checks++;
      if (bus0.m_valid !== ev || busy0 !== eb) begin
        failures++;
        $display("FAIL burst_valid c=%0d v=%b busy=%b want %b/%b",
                 c, bus0.m_valid, busy0, ev, eb);
      end
      if (ev) begin
        checks++;
        if (bus0.m_id !== 2'd2 || bus0.s_ready !== 4'b0100 ||
            bus0.m_data !== 32'hA000_0000 + 32'(c)) begin
          failures++;
          $display("FAIL burst_beat c=%0d id=%0d rdy=%b d=%h want 2/0100/%h",
                   c, bus0.m_id, bus0.s_ready, bus0.m_data,
                   32'hA000_0000 + 32'(c));
        end
      end
      tick();
    end
  endtask

  task automatic test_stall();
    do_reset();
    mr = 1'b1; sv = 4'b0010; sd[32 +: 32] = 32'h1111_0000;
    #1;
    tick();
    sd[32 +: 32] = 32'h1111_0001;
    #1;
    checks++;
    if (bus0.m_valid !== 1'b1 || bus0.m_id !== 2'd1 || bus0.s_ready !== 4'b0010) begin
      failures++;
      $display("FAIL stall_first v=%b id=%0d rdy=%b want 1/1/0010",
               bus0.m_valid, bus0.m_id, bus0.s_ready);
    end
    tick();
    mr = 1'b0; sd[32 +: 32] = 32'h1111_0002;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (bus0.m_valid !== 1'b1 || bus0.m_data !== 32'h1111_0002 ||
          bus0.s_ready !== 4'b0 || busy0 !== 1'b1) begin
        failures++;
        $display("FAIL stall_hold c=%0d v=%b d=%h rdy=%b want 1/11110002/0000",
                 c, bus0.m_valid, bus0.m_data, bus0.s_ready);
      end
      tick();
    end
    mr = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (bus0.m_valid !== 1'b1 || bus0.s_ready !== 4'b0010) begin
        failures++;
        $display("FAIL stall_resume c=%0d v=%b rdy=%b want 1/0010",
                 c, bus0.m_valid, bus0.s_ready);
      end
      tick();
    end
    #1;
    checks++;
    if (busy0 !== 1'b0) begin
      failures++;
      $display("FAIL stall_end busy=%b want 0", busy0);
    end
    sv = '0;
    tick();
  endtask

  task automatic test_drop();
    do_reset();
    mr = 1'b1; sv = 4'b1000;
    #1;
    tick();
    sv = 4'b1001;
    for (int c = 0; c < 2; c++) begin
      #1;
      checks++;
      if (bus0.m_id !== 2'd3 || bus0.m_valid !== 1'b1) begin
        failures++;
        $display("FAIL drop_beat c=%0d id=%0d v=%b want 3/1",
                 c, bus0.m_id, bus0.m_valid);
      end
      tick();
    end
    sv = 4'b0001;
    #1;
    checks++;
    if (bus0.m_valid !== 1'b0 || busy0 !== 1'b1) begin
      failures++;
      $display("FAIL drop_cycle v=%b busy=%b want 0/1", bus0.m_valid, busy0);
    end
    tick();
    #1;
    checks++;
    if (busy0 !== 1'b0) begin
      failures++;
      $display("FAIL drop_idle busy=%b want 0", busy0);
    end
    tick();
    #1;
    checks++;
    if (bus0.m_id !== 2'd0 || bus0.m_valid !== 1'b1) begin
      failures++;
      $display("FAIL drop_next id=%0d v=%b want 0/1", bus0.m_id, bus0.m_valid);
    end
    tick();
    sv = '0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    mr = 1'b1; sv = 4'b0010;
    #1; tick();
    #1; tick();
    sv = 4'b0100;
    #1; tick();
    #1; tick();
    #1;
    checks++;
    if (bus0.m_id !== 2'd2 || bus0.m_valid !== 1'b1) begin
      failures++;
      $display("FAIL rstmid_grant id=%0d v=%b want 2/1", bus0.m_id, bus0.m_valid);
    end
    tick();
    rst = 1'b1;
    #1;
    checks++;
    if (bus0.m_valid !== 1'b0 || bus0.s_ready !== 4'b0) begin
      failures++;
      $display("FAIL rstmid_nobeat v=%b rdy=%b want 0/0000",
               bus0.m_valid, bus0.s_ready);
    end
    tick();
    rst = 1'b0; sv = 4'b1010;
    #1;
    checks++;
    if (busy0 !== 1'b0 || bus0.s_ready !== 4'b0) begin
      failures++;
      $display("FAIL rstmid_after busy=%b rdy=%b want 0/0000", busy0, bus0.s_ready);
    end
    tick();
    #1;
    checks++;
    if (bus0.m_id !== 2'd1 || busy0 !== 1'b1) begin
      failures++;
      $display("FAIL rstmid_regrant id=%0d busy=%b want 1/1", bus0.m_id, busy0);
    end
    tick();
    sv = '0;
  endtask

  task automatic test_single_beat();
    do_reset();
    mr = 1'b1; sv = 4'b1111;
    for (int c = 0; c < 10; c++) begin
      logic ev;
      ev = (c % 2) == 1;
      #1;
      checks++;
      if (bus1.m_valid !== ev) begin
        failures++;
        $display("FAIL mb1_valid c=%0d v=%b want %b", c, bus1.m_valid, ev);
      end
      if (ev) begin
        checks++;
        if (bus1.m_id !== 2'((c / 2) % 4)) begin
          failures++;
          $display("FAIL mb1_id c=%0d id=%0d want %0d", c, bus1.m_id, (c / 2) % 4);
        end
      end
      tick();
    end
    sv = '0;
  endtask

`ifdef FIFO_RR_ARBITER_STATS_EN
  task automatic test_stats();
    do_reset();
    #1;
    checks++;
    if (bt0 !== 32'd0) begin
      failures++;
      $display("FAIL stats_zero got=%0d want 0", bt0);
    end
    mr = 1'b1; sv = 4'b0001;
    for (int c = 0; c < 13; c++) begin
      #1;
      tick();
    end
    sv = '0;
    #1;
    checks++;
    if (bt0 !== 32'd10 || bt0 !== 32'(tot[0])) begin
      failures++;
      $display("FAIL stats_count got=%0d want 10 (model %0d)", bt0, tot[0]);
    end
    do_reset();
    #1;
    checks++;
    if (bt0 !== 32'd0 || bt1 !== 32'd0) begin
      failures++;
      $display("FAIL stats_reset got=%0d/%0d want 0", bt0, bt1);
    end
  endtask
`endif

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 800; c++) begin
      logic [3:0] flip;
      for (int b = 0; b < 4; b++) flip[b] = ($urandom_range(0, 3) == 0);
      sv  = sv ^ flip;
      mr  = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 63) == 0);
      sd  = {$urandom, $urandom, $urandom, $urandom};
      #1;
      for (int u = 0; u < 2; u++) begin
        logic        ev, eb, av, ab;
        logic [1:0]  eid, aid;
        logic [31:0] ed, ad;
        logic [3:0]  er, ar;
        eb  = own[u] >= 0;
        ev  = eb && sv[own[u]] && !rst;
        eid = eb ? 2'(own[u]) : 2'd0;
        ed  = eb ? sd[own[u]*32 +: 32] : 32'd0;
        er  = (eb && mr && !rst) ? 4'(1 << own[u]) : 4'd0;
        av  = (u == 0) ? bus0.m_valid : bus1.m_valid;
        ab  = (u == 0) ? busy0 : busy1;
        aid = (u == 0) ? bus0.m_id : bus1.m_id;
        ad  = (u == 0) ? bus0.m_data : bus1.m_data;
        ar  = (u == 0) ? bus0.s_ready : bus1.s_ready;
        checks++;
        if (av !== ev || ab !== eb || aid !== eid || ad !== ed || ar !== er) begin
          failures++;
          $display("FAIL random u=%0d c=%0d got v=%b b=%b id=%0d d=%h r=%b want v=%b b=%b id=%0d d=%h r=%b",
                   u, c, av, ab, aid, ad, ar, ev, eb, eid, ed, er);
        end
      end
`ifdef FIFO_RR_ARBITER_STATS_EN
      checks++;
      if (bt0 !== 32'(tot[0]) || bt1 !== 32'(tot[1])) begin
        failures++;
        $display("FAIL random_stats c=%0d got %0d/%0d want %0d/%0d",
                 c, bt0, bt1, tot[0], tot[1]);
      end
`endif
      tick();
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; sv = '0; mr = 1'b0; sd = '0;
    @(negedge clk);
    test_reset();
    test_burst();
    test_stall();
    test_drop();
    test_reset_mid();
    test_single_beat();
`ifdef FIFO_RR_ARBITER_STATS_EN
    test_stats();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
